pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised fetch program-counter unit for the pipelined RISC-V core, replacing the bare PC register.
- Holds the fetch PC and selects the next PC from four sources, in priority order: trap, EX redirect, ID redirect, sequential step.
- Also supports stall, halt/resume, misaligned-target detection and a saturating redirect counter.
- Drives IF-stage fetch address and valid.

Parameters:
- XLEN, 32, PC and target width.
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- IALIGN, 32, instruction alignment: 32 or 16. A value of 16 enables 2-byte steps and halfword alignment.
- CNT_W, 16, redirect counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; sequential advance suppressed.
- step_half  in  1  sequential step is +2 instead of +4. Ignored (treated 0) when IALIGN=32.
- id_redirect_valid  in  1  jump resolved in ID.
- id_redirect_target  in  XLEN  ID target.
- ex_redirect_valid  in  1  branch/jalr resolved in EX.
- ex_redirect_target  in  XLEN  EX target.
- trap_valid  in  1  exception/interrupt entry.
- trap_target  in  XLEN  trap vector. Low bits are masked to alignment.
- halt_req  in  1  request halt.
- resume  in  1  leave halt.
- pc  out  XLEN  current fetch PC (registered).
- fetch_valid  out  1  pc is a valid fetch request.
- pc_plus_step  out  XLEN  combinational pc + step, used for link.
- halted  out  1  state == HALTED.
- misalign_trap  out  1  one-cycle pulse: a redirect target was misaligned.
- misalign_addr  out  XLEN  offending target, registered with the pulse.
- redirect_count  out  CNT_W  number of taken redirects (trap/EX/ID), saturating.

Behaviour:
- Reset values: pc=RESET_VECTOR, fetch_valid=0, state=BOOT, misalign_trap=0, misalign_addr=0, redirect_count=0. Reset wins over all other inputs, including mid-halt and mid-redirect.
- Step and alignment:
  - step = 2 if (IALIGN==16 && step_half), else 4.
  - Aligned means target[1:0]==0 for IALIGN=32, target[0]==0 for IALIGN=16.
  - All additions are modulo 2^XLEN. Wrap-around is silent (e.g. FFFF_FFFC+4 -> 0000_0000).
- BOOT state: lasts one cycle. pc holds, fetch_valid=0. Next edge -> RUN, fetch_valid=1, pc still RESET_VECTOR, so the first fetch is the reset vector. All inputs are ignored in BOOT.
- RUN state, per edge, first match wins:
  1. trap_valid: pc <= aligned trap_target, count++.
  2. ex_redirect_valid: if target aligned, pc <= target and count++; else pc holds, misalign_trap=1, misalign_addr=target. ID redirect is discarded.
  3. id_redirect_valid: same handling as EX.
  4. halt_req: -> HALTED, pc holds, fetch_valid <= 0.
  5. stall: pc holds.
  6. Otherwise: pc <= pc + step.
- Priority consequences:
  - Redirects override stall.
  - A halt_req arriving with a redirect is ignored that cycle; the requester holds it.
- HALTED state:
  - fetch_valid=0, halted=1.
  - trap_valid -> RUN with pc <= trap target (wake).
  - Otherwise resume -> RUN, pc unchanged, fetch_valid=1 next cycle.
  - EX/ID redirects update pc (with the same misalign rule) but the state stays HALTED.
  - stall and step have no effect.
- misalign_trap is high for exactly one cycle per misaligned redirect. A misaligned redirect does not increment the count.
- redirect_count saturates at 2^CNT_W-1.
- fetch_valid = (state==RUN), registered.

Decomposition:
- Shared package pc_pkg:
  - pc_state_e {BOOT, RUN, HALTED}.
  - redir_src_e {SRC_NONE, SRC_TRAP, SRC_EX, SRC_ID, SRC_SEQ}.
  - Step constants STEP_FULL=4, STEP_HALF=2.
- One sub-module, pc_next_sel (combinational): priority select plus alignment check. It outputs the chosen source, the next pc and the misalign flag.
- The state register, pc register and counter stay in pc_gen.

Test Plan:
- Reset and boot: hold reset 2 cycles, RESET_VECTOR=0x100. Expect pc=0x100 with fetch_valid=0 for one cycle, then 0x100 valid, then 0x104, 0x108.
- Stall and step_half (IALIGN=16): pc=0x200, stall 3 cycles -> pc stays 0x200. Release with step_half=1 -> 0x202, then step_half=0 -> 0x206.
- Simultaneous sources, all asserted with stall=1: trap=0x80, ex=0x400, id=0x500. Expect pc=0x80, count=1. Next cycle ex=0x400 and id=0x500 together -> pc=0x400, count=2.
- Misaligned redirect (IALIGN=32): ex target 0x302. Expect pc held, misalign_trap pulse of 1 cycle, misalign_addr=0x302, count unchanged.
- Halt, wake and resume:
  - halt_req at pc=0x40 -> halted=1, fetch_valid=0, pc=0x40.
  - ID redirect to 0x60 while halted -> pc=0x60, still halted.
  - resume -> RUN fetching 0x60, then 0x64.
  - Repeat the halt, then trap_valid target 0x87 -> pc=0x84, RUN.
- Wrap and saturation:
  - pc=FFFF_FFFC steps to 0000_0000.
  - With CNT_W=2, issue 5 taken redirects -> redirect_count=3.
  - Assert reset mid-halt -> all outputs return to reset values.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} pc_state_e;

  typedef enum logic [2:0] {SRC_NONE, SRC_TRAP, SRC_EX, SRC_ID, SRC_SEQ} redir_src_e;

  localparam int unsigned STEP_FULL = 4;
  localparam int unsigned STEP_HALF = 2;

endpackage

// File: rtl/pc_gen_if.sv
// Control and status bundle between the pipeline (master) and the fetch PC unit (slave).
interface pc_gen_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             stall;
  logic             step_half;
  logic             id_redirect_valid;
  logic [XLEN-1:0]  id_redirect_target;
  logic             ex_redirect_valid;
  logic [XLEN-1:0]  ex_redirect_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_target;
  logic             halt_req;
  logic             resume;
  logic [XLEN-1:0]  pc;
  logic             fetch_valid;
  logic [XLEN-1:0]  pc_plus_step;
  logic             halted;
  logic             misalign_trap;
  logic [XLEN-1:0]  misalign_addr;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output stall, step_half, id_redirect_valid, id_redirect_target, ex_redirect_valid,
           ex_redirect_target, trap_valid, trap_target, halt_req, resume,
    input  pc, fetch_valid, pc_plus_step, halted, misalign_trap, misalign_addr, redirect_count
  );

  modport slave (
    input  stall, step_half, id_redirect_valid, id_redirect_target, ex_redirect_valid,
           ex_redirect_target, trap_valid, trap_target, halt_req, resume,
    output pc, fetch_valid, pc_plus_step, halted, misalign_trap, misalign_addr, redirect_count
  );
endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority select (trap > EX > ID > sequential) with target alignment check.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 32
) (
  input  logic            run_i,
  input  logic            stall_i,
  input  logic            halt_req_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus_step_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_target_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_target_i,
  output redir_src_e      src_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] align_mask;
  logic            ex_ok;
  logic            id_ok;

  assign align_mask = (IALIGN == 16) ? ~XLEN'(1) : ~XLEN'(3);
  assign ex_ok      = (ex_target_i & ~align_mask) == '0;
  assign id_ok      = (id_target_i & ~align_mask) == '0;

  // A misaligned redirect still claims its slot so lower sources are dropped.
  always_comb begin
    src_o      = SRC_NONE;
    pc_next_o  = pc_i;
    misalign_o = 1'b0;
    if (trap_valid_i) begin
      src_o     = SRC_TRAP;
      pc_next_o = trap_target_i & align_mask;
    end else if (ex_valid_i) begin
      src_o = SRC_EX;
      if (ex_ok) pc_next_o = ex_target_i;
      else       misalign_o = 1'b1;
    end else if (id_valid_i) begin
      src_o = SRC_ID;
      if (id_ok) pc_next_o = id_target_i;
      else       misalign_o = 1'b1;
    end else if (run_i && !halt_req_i && !stall_i) begin
      src_o     = SRC_SEQ;
      pc_next_o = pc_plus_step_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: boot/run/halt control, redirect handling and redirect counter.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = 32,
  parameter int unsigned     CNT_W        = 16
) (
  input logic     clk,
  input logic     reset,
  pc_gen_if.slave bus
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  maddr_q, maddr_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  step;
  logic [XLEN-1:0]  pc_plus_step;
  logic [XLEN-1:0]  sel_pc_next;
  redir_src_e       sel_src;
  logic             sel_misalign;
  logic             taken;

  assign step = (IALIGN == 16 && bus.step_half) ? XLEN'(STEP_HALF) : XLEN'(STEP_FULL);
  assign pc_plus_step = pc_q + step;

  pc_next_sel #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_next_sel (
    .run_i          (state_q == RUN),
    .stall_i        (bus.stall),
    .halt_req_i     (bus.halt_req),
    .pc_i           (pc_q),
    .pc_plus_step_i (pc_plus_step),
    .trap_valid_i   (bus.trap_valid),
    .trap_target_i  (bus.trap_target),
    .ex_valid_i     (bus.ex_redirect_valid),
    .ex_target_i    (bus.ex_redirect_target),
    .id_valid_i     (bus.id_redirect_valid),
    .id_target_i    (bus.id_redirect_target),
    .src_o          (sel_src),
    .pc_next_o      (sel_pc_next),
    .misalign_o     (sel_misalign)
  );

  assign taken = (sel_src == SRC_TRAP || sel_src == SRC_EX || sel_src == SRC_ID) && !sel_misalign;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    maddr_d = maddr_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, HALTED: begin
        pc_d  = sel_pc_next;
        mis_d = sel_misalign;
        if (sel_misalign) begin
          maddr_d = (sel_src == SRC_EX) ? bus.ex_redirect_target : bus.id_redirect_target;
        end
        if (taken && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // Halt only when no redirect claimed the cycle; a trap wakes from halt.
        if (state_q == RUN) begin
          if (sel_src == SRC_NONE && bus.halt_req) state_d = HALTED;
        end else if (sel_src == SRC_TRAP || bus.resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    fetch_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      mis_q         <= 1'b0;
      maddr_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      mis_q         <= mis_d;
      maddr_q       <= maddr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.fetch_valid    = fetch_valid_q;
  assign bus.pc_plus_step   = pc_plus_step;
  assign bus.halted         = (state_q == HALTED);
  assign bus.misalign_trap  = mis_q;
  assign bus.misalign_addr  = maddr_q;
  assign bus.redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: one IALIGN=32/CNT_W=2 instance and one IALIGN=16 instance.
module tb_pc_gen;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    string       tag;
    bit          d16;
    logic [31:0] pc;
    logic        fv;
    logic        hl;
    logic        mt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  pc_gen_if #(.XLEN(32), .CNT_W(2))  if32 ();
  pc_gen_if #(.XLEN(32), .CNT_W(16)) if16 ();

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .IALIGN       (32),
    .CNT_W        (2)
  ) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (if32)
  );

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .IALIGN       (16),
    .CNT_W        (16)
  ) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clr();
    if32.stall = 0; if32.step_half = 0; if32.halt_req = 0; if32.resume = 0;
    if32.id_redirect_valid = 0; if32.id_redirect_target = '0;
    if32.ex_redirect_valid = 0; if32.ex_redirect_target = '0;
    if32.trap_valid = 0; if32.trap_target = '0;
    if16.stall = 0; if16.step_half = 0; if16.halt_req = 0; if16.resume = 0;
    if16.id_redirect_valid = 0; if16.id_redirect_target = '0;
    if16.ex_redirect_valid = 0; if16.ex_redirect_target = '0;
    if16.trap_valid = 0; if16.trap_target = '0;
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic cyc(input string tag, input bit d16, input logic [31:0] pc, input logic fv,
                     input logic hl, input logic mt, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.d16 = d16; e.pc = pc; e.fv = fv; e.hl = hl; e.mt = mt; e.cnt = cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.d16) begin
      check_eq({e.tag, ".pc"}, if16.pc, e.pc);
      check_eq({e.tag, ".fv"}, 32'(if16.fetch_valid), 32'(e.fv));
      check_eq({e.tag, ".halted"}, 32'(if16.halted), 32'(e.hl));
      check_eq({e.tag, ".mis"}, 32'(if16.misalign_trap), 32'(e.mt));
      check_eq({e.tag, ".cnt"}, 32'(if16.redirect_count), e.cnt);
    end else begin
      check_eq({e.tag, ".pc"}, if32.pc, e.pc);
      check_eq({e.tag, ".fv"}, 32'(if32.fetch_valid), 32'(e.fv));
      check_eq({e.tag, ".halted"}, 32'(if32.halted), 32'(e.hl));
      check_eq({e.tag, ".mis"}, 32'(if32.misalign_trap), 32'(e.mt));
      check_eq({e.tag, ".cnt"}, 32'(if32.redirect_count), e.cnt);
    end
  endtask

  initial begin
    clr();
    reset = 1'b1;
    cyc("rst0", 0, 32'h100, 0, 0, 0, 0);
    cyc("rst1", 0, 32'h100, 0, 0, 0, 0);
    check_eq("rst.maddr", if32.misalign_addr, 32'h0);
    reset = 1'b0;
    cyc("boot", 0, 32'h100, 1, 0, 0, 0);
    cyc("seq1", 0, 32'h104, 1, 0, 0, 0);
    if32.step_half = 1;  // ignored at IALIGN=32
    #0 check_eq("pps32", if32.pc_plus_step, 32'h108);
    cyc("seq2", 0, 32'h108, 1, 0, 0, 0);

    // All sources with stall: trap first, then EX over ID.
    clr();
    if32.stall = 1;
    if32.trap_valid = 1; if32.trap_target = 32'h80;
    if32.ex_redirect_valid = 1; if32.ex_redirect_target = 32'h400;
    if32.id_redirect_valid = 1; if32.id_redirect_target = 32'h500;
    cyc("prio.trap", 0, 32'h80, 1, 0, 0, 1);
    if32.trap_valid = 0;
    cyc("prio.ex", 0, 32'h400, 1, 0, 0, 2);
    clr(); if32.stall = 1;
    cyc("stall", 0, 32'h400, 1, 0, 0, 2);

    // Misaligned EX target: pc holds, one-cycle pulse, count unchanged.
    clr();
    if32.ex_redirect_valid = 1; if32.ex_redirect_target = 32'h302;
    cyc("mis.pulse", 0, 32'h400, 1, 0, 1, 2);
    check_eq("mis.addr", if32.misalign_addr, 32'h302);
    clr();
    cyc("mis.clear", 0, 32'h404, 1, 0, 0, 2);

    // Halt, redirect while halted, resume.
    if32.id_redirect_valid = 1; if32.id_redirect_target = 32'h40;
    cyc("to40", 0, 32'h40, 1, 0, 0, 3);
    clr(); if32.halt_req = 1;
    cyc("halt", 0, 32'h40, 0, 1, 0, 3);
    clr(); if32.id_redirect_valid = 1; if32.id_redirect_target = 32'h60;
    cyc("halt.id", 0, 32'h60, 0, 1, 0, 3);
    clr(); if32.stall = 1;
    cyc("halt.idle", 0, 32'h60, 0, 1, 0, 3);
    clr(); if32.resume = 1;
    cyc("resume", 0, 32'h60, 1, 0, 0, 3);
    clr();
    cyc("res.seq", 0, 32'h64, 1, 0, 0, 3);
    if32.halt_req = 1;
    cyc("halt2", 0, 32'h64, 0, 1, 0, 3);
    clr(); if32.trap_valid = 1; if32.trap_target = 32'h87;
    cyc("wake", 0, 32'h84, 1, 0, 0, 3);

    // Halt with a redirect is ignored; count saturated after five redirects.
    clr(); if32.halt_req = 1;
    if32.ex_redirect_valid = 1; if32.ex_redirect_target = 32'hFFFF_FFFC;
    cyc("halt.ign", 0, 32'hFFFF_FFFC, 1, 0, 0, 3);
    clr();
    cyc("wrap", 0, 32'h0, 1, 0, 0, 3);
    if32.halt_req = 1;
    cyc("halt3", 0, 32'h0, 0, 1, 0, 3);
    clr(); reset = 1'b1;
    if32.trap_valid = 1; if32.trap_target = 32'h500; if32.resume = 1;
    cyc("rst.halt", 0, 32'h100, 0, 0, 0, 0);
    check_eq("rst.maddr2", if32.misalign_addr, 32'h0);
    clr();
    cyc("rst.hold", 1, 32'h100, 0, 0, 0, 0);
    reset = 1'b0;

    // IALIGN=16 instance: half steps, halfword alignment.
    cyc("b16", 1, 32'h100, 1, 0, 0, 0);
    if16.ex_redirect_valid = 1; if16.ex_redirect_target = 32'h200;
    cyc("to200", 1, 32'h200, 1, 0, 0, 1);
    clr(); if16.stall = 1;
    for (int i = 0; i < 3; i++) cyc("st16", 1, 32'h200, 1, 0, 0, 1);
    clr(); if16.step_half = 1;
    #0 check_eq("pps16", if16.pc_plus_step, 32'h202);
    cyc("half", 1, 32'h202, 1, 0, 0, 1);
    if16.step_half = 0;
    cyc("full", 1, 32'h206, 1, 0, 0, 1);
    if16.ex_redirect_valid = 1; if16.ex_redirect_target = 32'h301;
    cyc("mis16", 1, 32'h206, 1, 0, 1, 1);
    check_eq("mis16.addr", if16.misalign_addr, 32'h301);
    if16.ex_redirect_target = 32'h302;
    cyc("hw16", 1, 32'h302, 1, 0, 0, 2);
    clr(); if16.trap_valid = 1; if16.trap_target = 32'h87;
    cyc("trap16", 1, 32'h86, 1, 0, 0, 3);
    clr();
    cyc("seq16", 1, 32'h8a, 1, 0, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
